// File: rtl/gcm_result_scroller_if.sv
// gcm_result_scroller_if: result inputs from the GCM core and display-side outputs of the scroller
interface gcm_result_scroller_if;
   logic [0:127] i_cipher_text;
   logic [0:127] i_tag;
   logic         i_tag_ready;
   logic         i_hold;
   logic         i_clear;
   logic [15:0]  o_x;
   logic [3:0]   o_index;
   logic         o_valid;
   logic         o_wrap;
   logic [7:0]   o_pass_count;
   modport master (
      output i_cipher_text, i_tag, i_tag_ready, i_hold, i_clear,
      input  o_x, o_index, o_valid, o_wrap, o_pass_count
   );
   modport slave (
      input  i_cipher_text, i_tag, i_tag_ready, i_hold, i_clear,
      output o_x, o_index, o_valid, o_wrap, o_pass_count
   );
endinterface

// File: rtl/gcm_result_scroller.sv
// gcm_result_scroller: captures cipher text and tag, then scrolls them 16 bits at a time to a display
module gcm_result_scroller #(
   parameter int DWELL_CYCLES = 50000000,
   parameter int DWELL_W      = $clog2(DWELL_CYCLES)
) (
   input logic                  clk,
   input logic                  i_reset_n,
   gcm_result_scroller_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SHOW = 1'b1;
   logic [0:0]         state_q, state_d;
   logic [0:255]       buf_q, buf_d;
   logic               tr_q;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [3:0]         idx_q, idx_d;
   logic               wrap_q, wrap_d;
   logic [7:0]         pass_q, pass_d;
   logic               rise, last;
   assign rise = bus.i_tag_ready & ~tr_q;
   assign last = dwell_q == DWELL_W'(DWELL_CYCLES - 1);
   // clear beats a new result, which beats hold; the buffer is left alone on clear since o_x is masked by state
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      dwell_d = dwell_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      pass_d  = pass_q;
      if (bus.i_clear) begin
         state_d = IDLE;
         dwell_d = '0;
         idx_d   = '0;
         pass_d  = '0;
      end else if (rise) begin
         state_d = SHOW;
         buf_d   = {bus.i_cipher_text, bus.i_tag};
         dwell_d = '0;
         idx_d   = '0;
         pass_d  = '0;
      end else if (state_q == SHOW && !bus.i_hold) begin
         dwell_d = last ? '0 : dwell_q + 1'b1;
         idx_d   = last ? idx_q + 4'd1 : idx_q;
         wrap_d  = last && idx_q == 4'hf;
         pass_d  = (last && idx_q == 4'hf && pass_q != 8'hff) ? pass_q + 8'd1 : pass_q;
      end
   end
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         buf_q   <= '0;
         tr_q    <= 1'b0;
         dwell_q <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         tr_q    <= bus.i_tag_ready;
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         pass_q  <= pass_d;
      end
   end
   assign bus.o_x          = (state_q == SHOW) ? buf_q[{idx_q, 4'b0000} +: 16] : 16'h0000;
   assign bus.o_index      = idx_q;
   assign bus.o_valid      = state_q == SHOW;
   assign bus.o_wrap       = wrap_q;
   assign bus.o_pass_count = pass_q;
endmodule
